// File: rtl/pfw_pkg.sv
// Shared definitions for the pattern frame writer: bus widths, FSM state
// encoding and pattern-mode codes.
package pfw_pkg;

    localparam int unsigned PIX_W  = 24;
    localparam int unsigned ADDR_W = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StWrite = ST_WRITE,
        StSend  = ST_SEND,
        StHold  = ST_HOLD
    } state_e;

    localparam logic [1:0] MODE_SOLID = 2'd0;
    localparam logic [1:0] MODE_GRAD  = 2'd1;
    localparam logic [1:0] MODE_COL   = 2'd2;
    localparam logic [1:0] MODE_CHECK = 2'd3;

endpackage

// File: rtl/pfw_pattern_gen.sv
// Combinational pixel generator for the 8x8 matrix.
// Ports:
//   mode   pattern select (solid, gradient, moving column, checkerboard)
//   color  foreground colour {R,G,B}
//   row    pixel row 0..7
//   col    pixel column 0..7
//   phase  animation phase
//   pixel  resulting colour {R,G,B}
module pfw_pattern_gen
    import pfw_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic [PIX_W-1:0] color,
    input  logic [2:0]       row,
    input  logic [2:0]       col,
    input  logic [7:0]       phase,
    output logic [PIX_W-1:0] pixel
);

    always_comb begin
        pixel = '0;
        case (mode)
            MODE_SOLID: pixel = color;
            // Red ramps with column, green with row, blue tracks the phase.
            MODE_GRAD:  pixel = {col, 5'b0, row, 5'b0, phase};
            MODE_COL:   pixel = (col == phase[2:0]) ? color : '0;
            MODE_CHECK: pixel = (row[0] ^ col[0] ^ phase[0]) ? color : '0;
            default:    pixel = '0;
        endcase
    end

endmodule

// File: rtl/pattern_frame_writer.sv
// Frame source for the DM163 colour-shield driver. Writes all 64 pixels of
// the current animated pattern, requests a frame send, waits FRAME_HOLD
// cycles and advances the animation phase.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   enable       start a new frame when idle
//   mode, color  pattern select and foreground colour, captured at frame start
//   ready        driver accepts a write or send this cycle
//   write_en     pixel write strobe (pixel_addr/pixel_value valid)
//   pixel_addr   {row, col}
//   pixel_value  pixel colour
//   send_frame   one-cycle request to latch and display the frame
//   frame_done   one-cycle pulse the cycle after send_frame
//   busy         high whenever not idle
module pattern_frame_writer
    import pfw_pkg::*;
#(
    parameter int unsigned FRAME_HOLD = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [PIX_W-1:0]  color,
    input  logic              ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_value,
    output logic              send_frame,
    output logic              frame_done,
    output logic              busy
);

    localparam int unsigned HOLD_W = $clog2(FRAME_HOLD + 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [7:0]          phase_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [1:0]          snap_mode_q;
    logic [PIX_W-1:0]    snap_color_q;
    logic                frame_done_q;
    logic [PIX_W-1:0]    gen_pixel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            phase_q      <= '0;
            hold_q       <= '0;
            snap_mode_q  <= '0;
            snap_color_q <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Snapshot the pattern so mid-frame input changes are ignored.
                    if (enable && ready) begin
                        snap_mode_q  <= mode;
                        snap_color_q <= color;
                        addr_q       <= '0;
                        state_q      <= StWrite;
                    end
                end
                StWrite: begin
                    if (ready) begin
                        if (addr_q == ADDR_W'(63)) begin
                            addr_q  <= '0;
                            state_q <= StSend;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                StSend: begin
                    if (ready) begin
                        phase_q      <= phase_q + 8'd1;
                        hold_q       <= HOLD_W'(FRAME_HOLD - 1);
                        frame_done_q <= 1'b1;
                        state_q      <= StHold;
                    end
                end
                StHold: begin
                    if (hold_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    pfw_pattern_gen u_pattern_gen (
        .mode  (snap_mode_q),
        .color (snap_color_q),
        .row   (addr_q[5:3]),
        .col   (addr_q[2:0]),
        .phase (phase_q),
        .pixel (gen_pixel)
    );

    // Write/send strobes follow ready directly so a stalled cycle issues nothing.
    always_comb begin
        write_en    = (state_q == StWrite) && ready;
        send_frame  = (state_q == StSend) && ready;
        pixel_addr  = (state_q == StWrite) ? addr_q : '0;
        pixel_value = (state_q == StWrite) ? gen_pixel : '0;
        frame_done  = frame_done_q;
        busy        = (state_q != StIdle);
    end

endmodule

// File: tb/tb_pattern_frame_writer.sv
module tb_pattern_frame_writer;

    localparam int unsigned HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'd0;
    logic        ready = 1'b0;
    logic        write_en;
    logic [5:0]  pixel_addr;
    logic [23:0] pixel_value;
    logic        send_frame;
    logic        frame_done;
    logic        busy;

    pattern_frame_writer #(.FRAME_HOLD(HOLD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .color       (color),
        .ready       (ready),
        .write_en    (write_en),
        .pixel_addr  (pixel_addr),
        .pixel_value (pixel_value),
        .send_frame  (send_frame),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          addr;
        logic [23:0] val;
    } wr_t;

    wr_t wq[$];
    int  lq[$];
    int  m_phase = 0;
    int  cyc = 0;
    int  rmode = 0;
    int  frame_writes = 0;
    int  lit = 0;
    logic prev_send = 1'b0;
    logic [23:0] v9 = 24'd0;
    int  t_first[$];
    int  t_send[$];
    int  t_done[$];
    wr_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference pixel from the pattern rules, using plain arithmetic.
    function automatic logic [23:0] ref_pixel(input int m, input logic [23:0] c,
                                              input int idx, input int ph);
        int row, col, r;
        row = idx / 8;
        col = idx % 8;
        case (m)
            0: return c;
            1: begin
                r = (col * 32) * 65536 + (row * 32) * 256 + ph;
                return 24'(r);
            end
            2: return (col == ph % 8) ? c : 24'd0;
            default: return (((row + col + ph) % 2) == 1) ? c : 24'd0;
        endcase
    endfunction

    task automatic push_frame(input int m, input logic [23:0] c);
        wr_t w;
        int  n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            w.addr = i;
            w.val  = ref_pixel(m, c, i, m_phase);
            if (w.val != 24'd0) n++;
            wq.push_back(w);
        end
        lq.push_back(n);
        m_phase = (m_phase + 1) % 256;
    endtask

    // Ready driver, changing just after the active edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: ready = 1'b1;
            1: ready = ~ready;
            2: ready = ($urandom_range(0, 3) != 0);
            default: ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!busy)
            check("idle_outputs", {write_en, send_frame, frame_done, pixel_addr, pixel_value},
                  64'd0);
        if (rst_n) begin
            if (frame_done || prev_send) check("frame_done", frame_done, prev_send);
            prev_send = send_frame;
            if (write_en) begin
                if (frame_writes == 0) t_first.push_back(cyc);
                if (wq.size() == 0) begin
                    fail("unexpected_write");
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", pixel_addr, e.addr);
                    check("wr_value", pixel_value, e.val);
                end
                if (pixel_addr == 6'd9) v9 = pixel_value;
                if (pixel_value != 24'd0) lit++;
                frame_writes++;
            end
            if (send_frame) begin
                t_send.push_back(cyc);
                check("writes_per_frame", frame_writes, 64);
                if (lq.size() == 0) fail("unexpected_send");
                else check("lit_pixels", lit, lq.pop_front());
                frame_writes = 0;
                lit = 0;
            end
            if (frame_done) t_done.push_back(cyc);
        end else begin
            frame_writes = 0;
            lit = 0;
            prev_send = 1'b0;
        end
    end

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int n;
        n = 0;
        while (busy !== lvl && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy !== lvl) fail(name);
    endtask

    task automatic wait_writes(input int target, input string name);
        int n;
        n = 0;
        while (frame_writes < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (frame_writes < target) fail(name);
    endtask

    task automatic run_frame(input int m, input logic [23:0] c);
        mode  = 2'(m);
        color = c;
        push_frame(m, c);
        enable = 1'b1;
        wait_busy(1'b1, 200, "frame_start_timeout");
        enable = 1'b0;
        wait_busy(1'b0, 2000, "frame_end_timeout");
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int t0;
    int busy_cycles;
    logic [23:0] c;

    initial begin
        // Reset state.
        #1;
        check("reset_outputs", {busy, write_en, send_frame, frame_done, pixel_addr, pixel_value},
              64'd0);
        settle(3);
        rst_n = 1'b1;

        // Idle with enable low.
        rmode = 0;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
        end
        check("idle_busy_cycles", busy_cycles, 0);

        // Backpressure, gradient with phase 0.
        rmode = 1;
        v9 = 24'd0;
        run_frame(1, 24'($urandom));
        check("bp_addr9", v9, 24'h202000);

        // Solid frame timing, two back-to-back frames.
        rmode = 0;
        settle(2);
        t_first.delete();
        t_send.delete();
        t_done.delete();
        mode  = 2'd0;
        color = 24'hFF0000;
        push_frame(0, 24'hFF0000);
        push_frame(0, 24'hFF0000);
        t0 = cyc;
        enable = 1'b1;
        for (int i = 0; i < 300 && t_first.size() < 2; i++) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        wait_busy(1'b0, 2000, "solid_end_timeout");
        if (t_first.size() < 2 || t_send.size() < 1 || t_done.size() < 1) begin
            fail("solid_events_missing");
        end else begin
            check("first_write_cycle", t_first[0] - t0, 1);
            check("send_cycle", t_send[0] - t0, 65);
            check("done_cycle", t_done[0] - t0, 66);
            check("next_frame_cycle", t_first[1] - t0, 66 + HOLD + 1);
        end

        // Randomized frames under random backpressure.
        rmode = 2;
        for (int i = 0; i < 12; i++) run_frame(int'($urandom_range(0, 3)), 24'($urandom));

        // Reset mid-WRITE.
        rmode = 0;
        settle(2);
        c = 24'($urandom) | 24'h1;
        mode  = 2'd1;
        color = c;
        push_frame(1, c);
        enable = 1'b1;
        wait_writes(30, "write30_timeout");
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {busy, write_en, send_frame, frame_done, pixel_addr, pixel_value}, 64'd0);
        wq.delete();
        lq.delete();
        m_phase = 0;
        enable = 1'b0;
        settle(2);
        rst_n = 1'b1;
        t_first.delete();
        run_frame(1, c);
        check("post_reset_frames", t_first.size(), 1);

        // Moving column over a full phase wrap.
        rst_n = 1'b0;
        settle(2);
        rst_n = 1'b1;
        m_phase = 0;
        for (int i = 0; i < 257; i++) run_frame(2, 24'h00FF00);
        run_frame(1, 24'd0);

        // Mid-frame enable drop and mode/colour change.
        c = 24'($urandom) | 24'h1;
        mode  = 2'd0;
        color = c;
        push_frame(0, c);
        enable = 1'b1;
        wait_writes(20, "write20_timeout");
        enable = 1'b0;
        mode   = 2'd3;
        color  = ~c;
        wait_busy(1'b0, 2000, "midframe_end_timeout");
        busy_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
        end
        check("stays_idle", busy_cycles, 0);
        check("scoreboard_drained", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
